fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Sequencing controller for the instruction fetch unit's PC register. Arbitrates redirect requests (exception, branch, jump) by fixed priority, holds a redirect pending while instruction memory is busy, and drives the fetch unit's `stall`/`rw`/`write` controls. Issues pipeline flushes and implements halt/resume. Sits between decode/execute hazard logic and the fetch unit.

## Interface
- `ADDR_WIDTH`, 16: PC width; `` `ADDR_BUS `` is `[ADDR_WIDTH-1:0]`.
- `EXC_VECTOR`, 16'h0004: exception handler address.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_ready`  in  1  instruction memory has valid data for the current PC.
- `hazard_stall`  in  1  load-use stall from decode.
- `exc_req`  in  1  exception raised in EX.
- `exc_pc`  in  ADDR  PC of the faulting instruction.
- `br_req`  in  1  taken branch resolved in EX.
- `br_target`  in  ADDR  branch target.
- `jmp_req`  in  1  jump decoded in ID.
- `jmp_target`  in  ADDR  jump target.
- `halt_req`  in  1  halt fetch.
- `resume`  in  1  leave HALT.
- `fu_stall`  out  1  to fetch unit `stall`.
- `fu_rw`  out  1  to fetch unit `rw`; `` `MEM_WRITE `` loads `fu_write`, otherwise `` `MEM_READ ``.
- `fu_write`  out  ADDR  redirect target.
- `flush_if_id`  out  1  squash IF/ID register.
- `flush_id_ex`  out  1  squash ID/EX register.
- `halted`  out  1  state is HALT.
- `epc`  out  ADDR  captured `exc_pc`.
- `redirect_cnt`  out  16  count of applied redirects; wraps modulo 2^16.

## Operation
- Priority: exception > branch > jump. Flush mapping: exception and branch assert `flush_if_id` and `flush_id_ex`; jump asserts `flush_if_id` only.
- States: RUN, PEND, HALT.
- RUN, no request:
  - `fu_stall = hazard_stall | !imem_ready`.
  - `fu_rw` = `` `MEM_READ ``.
- RUN, request present, `imem_ready=1`:
  - Apply the winner: `fu_stall=0`, `fu_rw` = `` `MEM_WRITE ``, `fu_write` = winner target (`EXC_VECTOR` for an exception).
  - Assert the winner's flushes; increment `redirect_cnt`.
  - `hazard_stall` is overridden.
- RUN, request present, `imem_ready=0`:
  - Latch winner target and kind into the pending register; go to PEND.
  - `fu_stall=1`; no flush this cycle.
- PEND:
  - `fu_stall=1` until `imem_ready=1`.
  - On `imem_ready=1`, apply the pending redirect exactly as in RUN and go to RUN.
  - A new strictly-higher-priority request replaces the pending entry. Equal or lower priority requests are dropped.
- `halt_req` in RUN with no request: go to HALT at the next edge.
- Simultaneous redirect and `halt_req`: the redirect wins and `halt_req` is ignored.
- HALT:
  - `fu_stall=1`, `halted=1`.
  - `resume` returns to RUN.
  - `exc_req` in HALT acts as a wake redirect through the same RUN rules, then goes to RUN; `br_req` and `jmp_req` are ignored.
- `epc` loads `exc_pc` on the cycle an exception is accepted (applied or latched), including a replacing exception in PEND.

## Timing
- Control outputs are combinational from state, pending register and inputs. `epc`, `redirect_cnt`, state and the pending register are registered.
- Redirect latency: request in cycle N with `imem_ready=1` → `pc == target` after edge N+1. Flushes are asserted in cycle N only.
- Pending redirect: applied in the first cycle with `imem_ready=1`; pc updates at the following edge.
- Reset values: state RUN, pending register cleared, `epc=0`, `redirect_cnt=0`, `halted=0`.
- During reset, `fu_stall=1` and `fu_rw` = `` `MEM_READ ``.
- Reset mid-PEND discards the pending redirect.
- `redirect_cnt` at 16'hFFFF wraps to 0 on the next applied redirect.

## Structure
- Shared defines header: state encodings (RUN/PEND/HALT), redirect-kind encoding (NONE/JMP/BR/EXC), and the existing `` `ADDR_BUS ``, `` `MEM_READ ``, `` `MEM_WRITE ``.
- One combinational sub-module, `fetch_redirect_arbiter`:
  - Inputs: the three requests.
  - Outputs: winning kind and target.
- The FSM, pending register, `epc` and counter live in `fetch_sequencer`.

## Test plan
- Reset, then `imem_ready=1` with no requests → `fu_stall=0`, `fu_rw` = `` `MEM_READ ``; pc increments 0,1,2.
- `br_req` with `br_target=16'h0040` and `jmp_req` with `jmp_target=16'h0080` in the same cycle → pc=0x0040 next edge; both flushes high for 1 cycle; `redirect_cnt=1`.
- `jmp_req` with target 0x0080 while `imem_ready=0` for 3 cycles, then `exc_req` (`exc_pc=0x0033`) in cycle 2 → pc=0x0004 after ready returns; `epc=0x0033`; jump dropped.
- `halt_req` → `halted=1` and pc frozen for 5 cycles; `resume` → counting restarts from the frozen pc+1.
- `exc_req` while halted → pc=0x0004, `halted=0`; `rst_n` low mid-PEND → pending cleared; pc=0 on release.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and encodings for the fetch sequencer and its redirect arbiter.
package fetch_sequencer_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StPend = 2'd1,
    StHalt = 2'd2
  } state_e;

  // Redirect kinds; the numeric order is the priority order (higher wins).
  typedef enum logic [1:0] {
    KindNone = 2'd0,
    KindJmp  = 2'd1,
    KindBr   = 2'd2,
    KindExc  = 2'd3
  } redirect_kind_e;

  // Fetch unit rw encodings.
  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  // Every redirect squashes IF/ID.
  function automatic logic kind_flushes_if_id(redirect_kind_e kind);
    return kind != KindNone;
  endfunction

  // Only exceptions and branches (resolved in EX) also squash ID/EX.
  function automatic logic kind_flushes_id_ex(redirect_kind_e kind);
    return (kind == KindExc) || (kind == KindBr);
  endfunction

endpackage

// File: rtl/fetch_redirect_arbiter.sv
// Fixed-priority redirect arbiter: exception > branch > jump.
module fetch_redirect_arbiter
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR = 'h0004
) (
  input  logic                  exc_req,
  input  logic                  br_req,
  input  logic [ADDR_WIDTH-1:0] br_target,
  input  logic                  jmp_req,
  input  logic [ADDR_WIDTH-1:0] jmp_target,
  output redirect_kind_e        kind,
  output logic [ADDR_WIDTH-1:0] target
);

  // Pick the highest-priority active request and its target.
  always_comb begin
    kind   = KindNone;
    target = '0;
    if (exc_req) begin
      kind   = KindExc;
      target = EXC_VECTOR;
    end else if (br_req) begin
      kind   = KindBr;
      target = br_target;
    end else if (jmp_req) begin
      kind   = KindJmp;
      target = jmp_target;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// PC sequencing controller: arbitrates redirects, parks one while imem is busy,
// drives the fetch unit stall/rw/write controls, flushes and halt/resume.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR = 'h0004
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  imem_ready,
  input  logic                  hazard_stall,
  input  logic                  exc_req,
  input  logic [ADDR_WIDTH-1:0] exc_pc,
  input  logic                  br_req,
  input  logic [ADDR_WIDTH-1:0] br_target,
  input  logic                  jmp_req,
  input  logic [ADDR_WIDTH-1:0] jmp_target,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic                  fu_stall,
  output logic                  fu_rw,
  output logic [ADDR_WIDTH-1:0] fu_write,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  halted,
  output logic [ADDR_WIDTH-1:0] epc,
  output logic [15:0]           redirect_cnt
);

  state_e                state_q, state_d;
  redirect_kind_e        pend_kind_q, pend_kind_d;
  logic [ADDR_WIDTH-1:0] pend_target_q, pend_target_d;
  logic [ADDR_WIDTH-1:0] epc_q, epc_d;
  logic [15:0]           cnt_q, cnt_d;

  redirect_kind_e        req_kind;
  logic [ADDR_WIDTH-1:0] req_target;
  redirect_kind_e        sel_kind;
  logic [ADDR_WIDTH-1:0] sel_target;
  logic                  in_halt;
  logic                  replace;
  logic                  have_req;
  logic                  apply;
  logic                  exc_accept;

  // Branches and jumps cannot wake a halted core; only exceptions can.
  assign in_halt = (state_q == StHalt);

  fetch_redirect_arbiter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_arbiter (
    .exc_req    (exc_req),
    .br_req     (br_req & ~in_halt),
    .br_target  (br_target),
    .jmp_req    (jmp_req & ~in_halt),
    .jmp_target (jmp_target),
    .kind       (req_kind),
    .target     (req_target)
  );

  // Choose between the parked redirect and a new request; only strictly higher
  // priority displaces what is parked.
  always_comb begin
    replace    = (state_q == StPend) && (req_kind > pend_kind_q);
    sel_kind   = req_kind;
    sel_target = req_target;
    if ((state_q == StPend) && !replace) begin
      sel_kind   = pend_kind_q;
      sel_target = pend_target_q;
    end
    have_req   = (sel_kind != KindNone);
    apply      = have_req && imem_ready;
    // A parked exception is not re-accepted by a later exception.
    exc_accept = (req_kind == KindExc) &&
                 ((state_q != StPend) || (pend_kind_q != KindExc));
  end

  // Next-state, pending register, epc and redirect counter.
  always_comb begin
    state_d       = state_q;
    pend_kind_d   = pend_kind_q;
    pend_target_d = pend_target_q;
    epc_d         = exc_accept ? exc_pc : epc_q;
    cnt_d         = apply ? cnt_q + 16'd1 : cnt_q;
    if (apply) begin
      state_d       = StRun;
      pend_kind_d   = KindNone;
      pend_target_d = '0;
    end else if (have_req) begin
      state_d       = StPend;
      pend_kind_d   = sel_kind;
      pend_target_d = sel_target;
    end else begin
      unique case (state_q)
        StRun:   if (halt_req) state_d = StHalt;
        StHalt:  if (resume) state_d = StRun;
        StPend:  state_d = StPend;
        default: state_d = StRun;
      endcase
    end
  end

  // Control outputs; reset forces a plain stalled read.
  always_comb begin
    fu_stall    = 1'b1;
    fu_rw       = MEM_READ;
    fu_write    = sel_target;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (rst_n) begin
      if (apply) begin
        fu_stall    = 1'b0;
        fu_rw       = MEM_WRITE;
        flush_if_id = kind_flushes_if_id(sel_kind);
        flush_id_ex = kind_flushes_id_ex(sel_kind);
      end else if ((state_q == StRun) && !have_req) begin
        fu_stall = hazard_stall | ~imem_ready;
      end
    end
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StRun;
      pend_kind_q   <= KindNone;
      pend_target_q <= '0;
      epc_q         <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pend_kind_q   <= pend_kind_d;
      pend_target_q <= pend_target_d;
      epc_q         <= epc_d;
      cnt_q         <= cnt_d;
    end
  end

  assign halted       = in_halt;
  assign epc          = epc_q;
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural PC register and a
// scoreboard of expected redirects.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        imem_ready;
  logic        hazard_stall;
  logic        exc_req;
  logic [15:0] exc_pc;
  logic        br_req;
  logic [15:0] br_target;
  logic        jmp_req;
  logic [15:0] jmp_target;
  logic        halt_req;
  logic        resume;
  logic        fu_stall;
  logic        fu_rw;
  logic [15:0] fu_write;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        halted;
  logic [15:0] epc;
  logic [15:0] redirect_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] target;
    logic        fl_if;
    logic        fl_id;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  logic [15:0] pc;

  fetch_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_ready   (imem_ready),
    .hazard_stall (hazard_stall),
    .exc_req      (exc_req),
    .exc_pc       (exc_pc),
    .br_req       (br_req),
    .br_target    (br_target),
    .jmp_req      (jmp_req),
    .jmp_target   (jmp_target),
    .halt_req     (halt_req),
    .resume       (resume),
    .fu_stall     (fu_stall),
    .fu_rw        (fu_rw),
    .fu_write     (fu_write),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .halted       (halted),
    .epc          (epc),
    .redirect_cnt (redirect_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Fetch unit PC model driven by the sequencer controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= '0;
    else if (!fu_stall) pc <= (fu_rw == MEM_WRITE) ? fu_write : pc + 16'd1;
  end

  // Scoreboard: every applied redirect must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n && !fu_stall && fu_rw == MEM_WRITE) begin
      checks++;
      assert (sb_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_redirect observed=%0h expected=none", fu_write);
      end
      if (sb_q.size() != 0) begin
        sb_e = sb_q.pop_front();
        checks++;
        assert ({fu_write, flush_if_id, flush_id_ex} === {sb_e.target, sb_e.fl_if, sb_e.fl_id})
        else begin
          errors++;
          $error("FAIL redirect observed=%0h/%0b%0b expected=%0h/%0b%0b", fu_write,
                 flush_if_id, flush_id_ex, sb_e.target, sb_e.fl_if, sb_e.fl_id);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] t, input logic fi, input logic fd);
    exp_t e;
    e.target = t;
    e.fl_if  = fi;
    e.fl_id  = fd;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b1; hazard_stall = 1'b0;
    exc_req = 1'b0; exc_pc = '0; br_req = 1'b0; br_target = '0;
    jmp_req = 1'b0; jmp_target = '0; halt_req = 1'b0; resume = 1'b0;

    // Reset values and outputs held during reset.
    #2;
    chk("rst_stall", fu_stall, 1);
    chk("rst_rw", fu_rw, MEM_READ);
    chk("rst_halted", halted, 0);
    chk("rst_epc", epc, 0);
    chk("rst_cnt", redirect_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Free-running sequential fetch.
    chk("run_stall", fu_stall, 0);
    chk("run_rw", fu_rw, MEM_READ);
    chk("pc0", pc, 16'h0000);
    tick(); chk("pc1", pc, 16'h0001);
    tick(); chk("pc2", pc, 16'h0002);

    // Branch beats jump in the same cycle and overrides hazard_stall.
    hazard_stall = 1'b1;
    br_req = 1'b1; br_target = 16'h0040;
    jmp_req = 1'b1; jmp_target = 16'h0080;
    push(16'h0040, 1'b1, 1'b1);
    #1;
    chk("br_stall_override", fu_stall, 0);
    chk("br_flush_if", flush_if_id, 1);
    chk("br_flush_id", flush_id_ex, 1);
    tick();
    br_req = 1'b0; jmp_req = 1'b0;
    #1;
    chk("hazard_stall", fu_stall, 1);
    chk("br_flush_one_cycle", {flush_if_id, flush_id_ex}, 2'b00);
    chk("br_cnt", redirect_cnt, 1);
    tick();
    chk("br_pc", pc, 16'h0040);
    hazard_stall = 1'b0;

    // Jump parked while busy, replaced by a later exception; jump dropped.
    imem_ready = 1'b0;
    jmp_req = 1'b1; jmp_target = 16'h0080;
    #1;
    chk("pend_stall", fu_stall, 1);
    chk("pend_no_flush", flush_if_id, 0);
    tick();
    jmp_req = 1'b0;
    exc_req = 1'b1; exc_pc = 16'h0033;
    push(16'h0004, 1'b1, 1'b1);
    tick();
    exc_req = 1'b0; jmp_req = 1'b1;
    #1;
    chk("pend_epc", epc, 16'h0033);
    chk("pend_pc_held", pc, 16'h0040);
    tick();
    jmp_req = 1'b0; imem_ready = 1'b1;
    #1;
    chk("pend_apply_rw", fu_rw, MEM_WRITE);
    tick();
    chk("exc_pc", pc, 16'h0004);
    chk("exc_cnt", redirect_cnt, 2);

    // Halt, ignore a branch while halted, then resume.
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("halted", halted, 1);
    chk("halt_pc", pc, 16'h0005);
    br_req = 1'b1; br_target = 16'h0099;
    tick();
    br_req = 1'b0;
    repeat (4) tick();
    chk("halt_frozen", pc, 16'h0005);
    chk("halt_stall", fu_stall, 1);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("resumed", halted, 0);
    tick();
    chk("resume_pc", pc, 16'h0006);

    // Exception wakes a halted core.
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    exc_req = 1'b1; exc_pc = 16'h0077;
    push(16'h0004, 1'b1, 1'b1);
    #1;
    chk("wake_halted_before", halted, 1);
    chk("wake_stall", fu_stall, 0);
    tick();
    exc_req = 1'b0;
    chk("wake_pc", pc, 16'h0004);
    chk("wake_halted", halted, 0);
    chk("wake_epc", epc, 16'h0077);
    chk("wake_cnt", redirect_cnt, 3);

    // Reset while a branch is parked discards it.
    imem_ready = 1'b0;
    br_req = 1'b1; br_target = 16'h0099;
    tick();
    br_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_stall", fu_stall, 1);
    chk("midrst_rw", fu_rw, MEM_READ);
    chk("midrst_cnt", redirect_cnt, 0);
    rst_n = 1'b1; imem_ready = 1'b1;
    #0.5;
    chk("midrst_pc0", pc, 16'h0000);
    tick();
    chk("midrst_pc1", pc, 16'h0001);

    // Counter wraps from 16'hFFFF to 0.
    jmp_req = 1'b1; jmp_target = 16'h0010;
    for (int i = 0; i < 65535; i++) begin
      push(16'h0010, 1'b1, 1'b0);
      tick();
    end
    chk("cnt_max", redirect_cnt, 16'hFFFF);
    chk("jmp_pc", pc, 16'h0010);
    push(16'h0010, 1'b1, 1'b0);
    tick();
    jmp_req = 1'b0;
    chk("cnt_wrap", redirect_cnt, 16'h0000);
    tick();

    chk("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
